async_fifo_lvl: RTL and testbench

Dual-clock FIFO for moving sensor samples from the acquisition clock domain (wr_clk) to the processing domain (rd_clk). It generalises the team's basic gray-pointer async FIFO with:
- configurable synchroniser depth
- per-domain fill levels
- programmable almost-full / almost-empty thresholds
- sticky overflow / underflow error flags

It sits between the sensor front-end packer and the DMA/packetiser stage.

---
 rtl/async_fifo_lvl_if.sv | 42 ++++
 rtl/async_fifo_lvl.sv | 133 +++++++++++++
 tb/tb_async_fifo_lvl.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/async_fifo_lvl_if.sv
// Request, payload and status bundle for async_fifo_lvl; master issues requests, slave is the FIFO.
// rd_parity_err exists only when ASYNC_FIFO_PARITY_EN is defined.
interface async_fifo_lvl_if #(
  parameter int unsigned DATA_WIDTH = 64,
  parameter int unsigned DEPTH_LOG2 = 4
);
  logic                  wr_en;
  logic [DATA_WIDTH-1:0] wr_data;
  logic                  full;
  logic                  almost_full;
  logic [DEPTH_LOG2:0]   wr_level;
  logic                  wr_overflow;
  logic                  wr_ovf_clr;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  empty;
  logic                  almost_empty;
  logic [DEPTH_LOG2:0]   rd_level;
  logic                  rd_underflow;
  logic                  rd_unf_clr;
`ifdef ASYNC_FIFO_PARITY_EN
  logic                  rd_parity_err;
`endif

  modport master (
`ifdef ASYNC_FIFO_PARITY_EN
    input  rd_parity_err,
`endif
    output wr_en, wr_data, wr_ovf_clr, rd_en, rd_unf_clr,
    input  full, almost_full, wr_level, wr_overflow,
    input  rd_data, empty, almost_empty, rd_level, rd_underflow
  );

  modport slave (
`ifdef ASYNC_FIFO_PARITY_EN
    output rd_parity_err,
`endif
    input  wr_en, wr_data, wr_ovf_clr, rd_en, rd_unf_clr,
    output full, almost_full, wr_level, wr_overflow,
    output rd_data, empty, almost_empty, rd_level, rd_underflow
  );
endinterface

// File: rtl/async_fifo_lvl.sv
// Dual-clock gray-pointer FIFO with per-domain fill levels, threshold flags and sticky error flags.
// Define ASYNC_FIFO_PARITY_EN to store an even-parity bit per entry and flag mismatches on pop.
module async_fifo_lvl #(
  parameter int unsigned DATA_WIDTH    = 64,
  parameter int unsigned DEPTH_LOG2    = 4,
  parameter int unsigned SYNC_STAGES   = 2,
  parameter int unsigned AFULL_THRESH  = (1 << DEPTH_LOG2) - 4,
  parameter int unsigned AEMPTY_THRESH = 2
) (
  input logic              wr_clk,
  input logic              wr_rst_n,
  input logic              rd_clk,
  input logic              rd_rst_n,
  async_fifo_lvl_if.slave  bus
);
  localparam int unsigned PtrW = DEPTH_LOG2 + 1;
  localparam int unsigned AddrW = DEPTH_LOG2;
`ifdef ASYNC_FIFO_PARITY_EN
  localparam int unsigned MemW = DATA_WIDTH + 1;
`else
  localparam int unsigned MemW = DATA_WIDTH;
`endif
  localparam logic [PtrW-1:0] AfullLvl  = PtrW'(AFULL_THRESH);
  localparam logic [PtrW-1:0] AemptyLvl = PtrW'(AEMPTY_THRESH);

  function automatic logic [PtrW-1:0] gray2bin(input logic [PtrW-1:0] g);
    logic [PtrW-1:0] bin;
    bin[PtrW-1] = g[PtrW-1];
    for (int i = int'(PtrW) - 2; i >= 0; i--) bin[i] = bin[i+1] ^ g[i];
    return bin;
  endfunction

  logic [MemW-1:0] mem [2**AddrW];

  logic [PtrW-1:0] wr_bin_q, wr_bin_d, wr_gray_q, wr_gray_d, rd_gray_wr, wr_level;
  logic [PtrW-1:0] rd_bin_q, rd_bin_d, rd_gray_q, rd_gray_d, wr_gray_rd, rd_level;
  logic [PtrW-1:0] rd_gray_sync_q [SYNC_STAGES];
  logic [PtrW-1:0] wr_gray_sync_q [SYNC_STAGES];
  logic            full, wr_push, wr_ovf_q, wr_ovf_d;
  logic            empty, rd_pop, rd_unf_q, rd_unf_d;
  logic [MemW-1:0] wr_word, head;

  // ---------------- write domain ----------------
`ifdef ASYNC_FIFO_PARITY_EN
  assign wr_word = {^bus.wr_data, bus.wr_data};
`else
  assign wr_word = bus.wr_data;
`endif

  always_comb begin
    rd_gray_wr = rd_gray_sync_q[SYNC_STAGES-1];
    // Full when the write pointer is exactly one lap ahead of the read pointer.
    full      = (wr_gray_q == {~rd_gray_wr[PtrW-1 -: 2], rd_gray_wr[PtrW-3:0]});
    wr_level  = wr_bin_q - gray2bin(rd_gray_wr);
    wr_push   = bus.wr_en && !full;
    wr_bin_d  = wr_bin_q + PtrW'(wr_push);
    wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
    wr_ovf_d  = wr_ovf_q;
    if (bus.wr_en && full) wr_ovf_d = 1'b1;
    else if (bus.wr_ovf_clr) wr_ovf_d = 1'b0;
  end

  always_ff @(posedge wr_clk or negedge wr_rst_n) begin
    if (!wr_rst_n) begin
      wr_bin_q  <= '0;
      wr_gray_q <= '0;
      wr_ovf_q  <= 1'b0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) rd_gray_sync_q[i] <= '0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      wr_gray_q <= wr_gray_d;
      wr_ovf_q  <= wr_ovf_d;
      rd_gray_sync_q[0] <= rd_gray_q;
      for (int i = 1; i < int'(SYNC_STAGES); i++) rd_gray_sync_q[i] <= rd_gray_sync_q[i-1];
    end
  end

  always_ff @(posedge wr_clk) begin
    if (wr_push) mem[wr_bin_q[AddrW-1:0]] <= wr_word;
  end

  assign bus.full        = full;
  assign bus.almost_full = (wr_level >= AfullLvl);
  assign bus.wr_level    = wr_level;
  assign bus.wr_overflow = wr_ovf_q;

  // ---------------- read domain ----------------
  always_comb begin
    wr_gray_rd = wr_gray_sync_q[SYNC_STAGES-1];
    empty      = (rd_gray_q == wr_gray_rd);
    rd_level   = gray2bin(wr_gray_rd) - rd_bin_q;
    rd_pop     = bus.rd_en && !empty;
    rd_bin_d   = rd_bin_q + PtrW'(rd_pop);
    rd_gray_d  = rd_bin_d ^ (rd_bin_d >> 1);
    rd_unf_d   = rd_unf_q;
    if (bus.rd_en && empty) rd_unf_d = 1'b1;
    else if (bus.rd_unf_clr) rd_unf_d = 1'b0;
  end

  assign head = mem[rd_bin_q[AddrW-1:0]];

`ifdef ASYNC_FIFO_PARITY_EN
  logic rd_par_err_q;
  assign bus.rd_parity_err = rd_par_err_q;
`endif

  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      rd_bin_q  <= '0;
      rd_gray_q <= '0;
      rd_unf_q  <= 1'b0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) wr_gray_sync_q[i] <= '0;
`ifdef ASYNC_FIFO_PARITY_EN
      rd_par_err_q <= 1'b0;
`endif
    end else begin
      rd_bin_q  <= rd_bin_d;
      rd_gray_q <= rd_gray_d;
      rd_unf_q  <= rd_unf_d;
      wr_gray_sync_q[0] <= wr_gray_q;
      for (int i = 1; i < int'(SYNC_STAGES); i++) wr_gray_sync_q[i] <= wr_gray_sync_q[i-1];
`ifdef ASYNC_FIFO_PARITY_EN
      rd_par_err_q <= rd_pop && (head[DATA_WIDTH] != ^head[DATA_WIDTH-1:0]);
`endif
    end
  end

  assign bus.rd_data      = head[DATA_WIDTH-1:0];
  assign bus.empty        = empty;
  assign bus.almost_empty = (rd_level <= AemptyLvl);
  assign bus.rd_level     = rd_level;
  assign bus.rd_underflow = rd_unf_q;
endmodule

// File: tb/tb_async_fifo_lvl.sv
// Self-checking bench for async_fifo_lvl: directed fill/drain tables, flag corner cases,
// sync latency for two synchroniser depths, and random traffic against a queue model.
`timescale 1ns/100ps
module tb_async_fifo_lvl;
  localparam int unsigned DW = 64;
  localparam int unsigned AW = 4;
  localparam int Depth = 16;

  logic wr_clk = 1'b0;
  logic rd_clk = 1'b0;
  logic wr_rst_n = 1'b0;
  logic rd_rst_n = 1'b0;
  bit   aligned = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  async_fifo_lvl_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(AW)) b ();
  async_fifo_lvl_if #(.DATA_WIDTH(DW), .DEPTH_LOG2(AW)) b3 ();

  async_fifo_lvl #(.DATA_WIDTH(DW), .DEPTH_LOG2(AW), .SYNC_STAGES(2)) dut (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .bus(b)
  );
  async_fifo_lvl #(.DATA_WIDTH(DW), .DEPTH_LOG2(AW), .SYNC_STAGES(3)) dut3 (
    .wr_clk(wr_clk), .wr_rst_n(wr_rst_n), .rd_clk(rd_clk), .rd_rst_n(rd_rst_n), .bus(b3)
  );

  // 100 MHz write clock; read clock either tracks it edge-for-edge or free-runs at ~37 MHz.
  always #5 begin
    wr_clk = ~wr_clk;
    if (aligned) rd_clk = wr_clk;
  end
  initial forever begin
    #13.5;
    if (!aligned) rd_clk = ~rd_clk;
  end

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation time limit reached, got hang expected completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic idle();
    b.wr_en = 0; b.wr_data = '0; b.wr_ovf_clr = 0; b.rd_en = 0; b.rd_unf_clr = 0;
    b3.wr_en = 0; b3.wr_data = '0; b3.wr_ovf_clr = 0; b3.rd_en = 0; b3.rd_unf_clr = 0;
  endtask

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge wr_clk);
      #1;
    end
  endtask

  task automatic do_reset();
    idle();
    wr_rst_n = 0;
    rd_rst_n = 0;
    repeat (3) @(posedge wr_clk);
    #1;
    wr_rst_n = 1;
    rd_rst_n = 1;
    #1;
  endtask

  // Random/streaming traffic; q holds every word the model says is in flight or stored.
  task automatic stream(input int n, input int wp, input int rp, input int rd_delay);
    logic [63:0] q[$];
    int n_wr = 0;
    int n_rd = 0;
    fork
      begin
        int guard = 0;
        logic [63:0] d;
        while (n_wr < n && guard < 20000) begin
          @(posedge wr_clk);
          #1;
          guard++;
          check("wr_level bound", (b.wr_level <= 5'(Depth)) && (int'(b.wr_level) >= q.size()), 1);
          b.wr_en = 0;
          if (!b.full && $urandom_range(99) < wp) begin
            d = {$urandom, $urandom};
            b.wr_data = d;
            b.wr_en = 1;
            q.push_back(d);
            n_wr++;
          end
        end
        @(posedge wr_clk);
        #1;
        b.wr_en = 0;
        check("stream wr count", n_wr, n);
      end
      begin
        int guard = 0;
        while (n_rd < n && guard < 20000) begin
          @(posedge rd_clk);
          #1;
          guard++;
          check("rd_level bound", (b.rd_level <= 5'(Depth)) && (int'(b.rd_level) <= q.size()), 1);
`ifdef ASYNC_FIFO_PARITY_EN
          check("parity err", b.rd_parity_err, 0);
`endif
          b.rd_en = 0;
          if (!b.empty && guard > rd_delay && $urandom_range(99) < rp) begin
            if (q.size() == 0) check("model nonempty", 0, 1);
            else check("stream data", b.rd_data, q.pop_front());
            b.rd_en = 1;
            n_rd++;
          end
        end
        @(posedge rd_clk);
        #1;
        b.rd_en = 0;
        check("stream rd count", n_rd, n);
      end
    join
  endtask

  typedef struct {
    logic [63:0] data;
    logic        full;
    logic        af;
    logic [4:0]  lvl;
    logic        ovf;
  } wvec_t;

  typedef struct {
    logic [63:0] data;
    logic [4:0]  lvl;
    logic        ae;
  } rvec_t;

  wvec_t wv[17];
  rvec_t rv[16];

  initial begin
    for (int i = 0; i < 17; i++) begin
      int l;
      l = (i + 1 > Depth) ? Depth : i + 1;
      wv[i].data = (i < 16) ? 64'(i) : 64'hDEAD_BEEF;
      wv[i].lvl  = 5'(l);
      wv[i].full = (l == Depth);
      wv[i].af   = (l >= 12);
      wv[i].ovf  = (i == 16);
    end
    for (int i = 0; i < 16; i++) begin
      rv[i].data = 64'(i);
      rv[i].lvl  = 5'(Depth - i);
      rv[i].ae   = ((Depth - i) <= 2);
    end

    do_reset();
    check("rst full", b.full, 0);
    check("rst almost_full", b.almost_full, 0);
    check("rst wr_level", b.wr_level, 0);
    check("rst wr_overflow", b.wr_overflow, 0);
    check("rst empty", b.empty, 1);
    check("rst almost_empty", b.almost_empty, 1);
    check("rst rd_level", b.rd_level, 0);
    check("rst rd_underflow", b.rd_underflow, 0);

    // Fill to full plus one overflowing write.
    for (int i = 0; i < 17; i++) begin
      b.wr_data = wv[i].data;
      b.wr_en = 1;
      tick();
      b.wr_en = 0;
      check($sformatf("fill%0d wr_level", i), b.wr_level, wv[i].lvl);
      check($sformatf("fill%0d full", i), b.full, wv[i].full);
      check($sformatf("fill%0d almost_full", i), b.almost_full, wv[i].af);
      check($sformatf("fill%0d wr_overflow", i), b.wr_overflow, wv[i].ovf);
    end

    // Sticky overflow: clear alone, set+clear together, clear again.
    b.wr_ovf_clr = 1; tick(); b.wr_ovf_clr = 0;
    check("ovf cleared", b.wr_overflow, 0);
    b.wr_data = 64'hBAD; b.wr_en = 1; b.wr_ovf_clr = 1; tick(); idle();
    check("ovf set wins", b.wr_overflow, 1);
    check("ovf level kept", b.wr_level, 16);
    b.wr_ovf_clr = 1; tick(); b.wr_ovf_clr = 0;
    check("ovf later clear", b.wr_overflow, 0);

    // Drain: data must be 0..F with no trace of the dropped writes.
    tick(4);
    for (int i = 0; i < 16; i++) begin
      check($sformatf("drain%0d rd_data", i), b.rd_data, rv[i].data);
      check($sformatf("drain%0d rd_level", i), b.rd_level, rv[i].lvl);
      check($sformatf("drain%0d almost_empty", i), b.almost_empty, rv[i].ae);
      check($sformatf("drain%0d empty", i), b.empty, 0);
      b.rd_en = 1; tick(); b.rd_en = 0;
    end
    check("drained empty", b.empty, 1);
    check("drained rd_level", b.rd_level, 0);
    check("drained almost_empty", b.almost_empty, 1);
    check("drained rd_underflow", b.rd_underflow, 0);
    b.rd_en = 1; tick(); b.rd_en = 0;
    check("unf set", b.rd_underflow, 1);
    check("unf rd_level", b.rd_level, 0);
    b.rd_unf_clr = 1; tick(); b.rd_unf_clr = 0;
    check("unf cleared", b.rd_underflow, 0);
    tick(4);
    check("drained wr_level", b.wr_level, 0);
    check("drained full", b.full, 0);

    // Write-to-empty latency: edge 1 is the write edge itself.
    do_reset();
    b.wr_data = 64'hA5A5; b.wr_en = 1;
    b3.wr_data = 64'h5A5A; b3.wr_en = 1;
    for (int k = 1; k <= 5; k++) begin
      @(posedge wr_clk);
      #1;
      if (k == 1) begin b.wr_en = 0; b3.wr_en = 0; end
      check($sformatf("lat s2 edge%0d empty", k), b.empty, (k <= 2));
      check($sformatf("lat s3 edge%0d empty", k), b3.empty, (k <= 3));
    end
    check("lat s2 rd_data", b.rd_data, 64'hA5A5);
    check("lat s3 rd_data", b3.rd_data, 64'h5A5A);
    check("lat s3 rd_level", b3.rd_level, 1);

    // Pointer wrap: 40 words at roughly half occupancy.
    do_reset();
    stream(40, 100, 100, 8);
    tick(6);
    check("wrap wr_level", b.wr_level, 0);
    check("wrap rd_level", b.rd_level, 0);
    check("wrap empty", b.empty, 1);

    // Free-running clocks, random enables.
    aligned = 0;
    stream(1000, 60, 50, 0);
    repeat (6) @(posedge rd_clk);
    #1;
    check("rand empty", b.empty, 1);
    check("rand rd_level", b.rd_level, 0);
    check("rand rd_underflow", b.rd_underflow, 0);
    repeat (6) @(posedge wr_clk);
    #1;
    check("rand wr_level", b.wr_level, 0);
    check("rand wr_overflow", b.wr_overflow, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
